// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage CPU: exception vector, hazard encodings,
// pipeline-controller state encoding and default multiply/divide latencies.
package cpu_pkg;

    localparam logic [31:0] EXC_VECTOR      = 32'h0000_4180;
    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam int unsigned MD_MULT_CYCLES  = 5;
    localparam int unsigned MD_DIV_CYCLES   = 10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTRY = 2'd1,
        RET   = 2'd2
    } ctrl_state_t;

    // A producer in flight still owes its result after the consumer needs it.
    function automatic logic raw_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return (src != 5'd0) && (src == dst) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_timer.sv
// Multiply/divide busy timer: a 4-bit down-counter loaded on an MD start.
module md_timer
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    input  logic kill,
    output logic busy
);

    logic [3:0] cnt_q, cnt_d;

    // A start being flushed is dropped; a running count keeps going.
    always_comb begin
        cnt_d = cnt_q;
        if (start && !kill) begin
            cnt_d = div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != 4'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: RAW/MD stall generation, exception entry request
// and eret flush sequencing.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] E_RegAddr,
    input  logic [4:0] M_RegAddr,
    input  logic [1:0] E_Tnew,
    input  logic [1:0] M_Tnew,
    input  logic       D_isMD,
    input  logic       E_mdStart,
    input  logic       E_mdDiv,
    input  logic [4:0] M_excCode,
    input  logic       int_pend,
    input  logic       M_eret,
    output logic       stall,
    output logic       req,
    output logic       eret_flush,
    output logic       md_busy
);

    ctrl_state_t state_q, state_d;
    logic        busy;
    logic        req_raw;
    logic        eret_raw;
    logic        stall_rs, stall_rt, stall_md;
    logic        exc;

    md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .start (E_mdStart),
        .div   (E_mdDiv),
        .kill  (req_raw),
        .busy  (busy)
    );

    always_comb begin
        stall_rs = raw_hazard(D_rs, D_Tuse_rs, E_RegAddr, E_Tnew)
                 | raw_hazard(D_rs, D_Tuse_rs, M_RegAddr, M_Tnew);
        stall_rt = raw_hazard(D_rt, D_Tuse_rt, E_RegAddr, E_Tnew)
                 | raw_hazard(D_rt, D_Tuse_rt, M_RegAddr, M_Tnew);
        stall_md = D_isMD & (busy | E_mdStart);
        exc      = (M_excCode != 5'd0) | int_pend;
    end

    // Interrupt/exception beats a simultaneous eret; ENTRY and RET are single
    // bubble cycles in which neither redirect is re-issued.
    always_comb begin
        state_d  = state_q;
        req_raw  = 1'b0;
        eret_raw = 1'b0;
        unique case (state_q)
            RUN: begin
                if (exc) begin
                    req_raw = 1'b1;
                    state_d = ENTRY;
                end else if (M_eret) begin
                    eret_raw = 1'b1;
                    state_d  = RET;
                end
            end
            ENTRY:   state_d = RUN;
            RET:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        req        = req_raw & ~reset;
        eret_flush = eret_raw & ~reset;
        stall      = (stall_rs | stall_rt | stall_md) & ~req_raw & ~reset;
        md_busy    = busy & ~reset;
    end

endmodule
